// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver and its companions.
// Parity mode codes, receive FSM states and a constant-friendly ceil(log2).
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DELIVER
  } rx_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Fractional-accumulator oversampling tick: one pulse per OVS-th of a bit time.
// Shared between the receiver and the future transmitter.
module uart_os_tick #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int OVS    = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int ACC_W = 16;
  localparam longint unsigned NUM =
    longint'(BAUD) * longint'(OVS) * (64'd1 << ACC_W);
  localparam longint unsigned INC_FULL =
    (64'd2 * NUM + longint'(CLK_HZ)) / (64'd2 * longint'(CLK_HZ));
  localparam logic [ACC_W:0] INC = INC_FULL[ACC_W:0];

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W:0]   sum_d;

  // The carry out of the accumulator is the tick; the low bits keep the phase.
  assign sum_d = {1'b0, acc_q} + INC;
  assign tick  = sum_d[ACC_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= sum_d[ACC_W-1:0];
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled, majority-filtered, with parity,
// framing, break and overrun reporting behind a valid/ready output register.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 50000000,
  parameter int BAUD      = 115200,
  parameter int OVS       = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int IDLE_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun,
  output logic                 rx_idle
);

  if (longint'(CLK_HZ) < longint'(BAUD) * longint'(OVS)) begin : g_bad_clk
    $error("uart_rx_param: CLK_HZ must be at least BAUD*OVS");
  end
  if (OVS < 8 || OVS > 32 || (OVS & (OVS - 1)) != 0) begin : g_bad_ovs
    $error("uart_rx_param: OVS must be a power of 2 in 8..32");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_rx_param: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_rx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end

  localparam int SC_W     = clog2(OVS);
  localparam int BC_W     = clog2(DATA_BITS + 1);
  localparam int IDLE_MAX = IDLE_BITS * OVS;
  localparam int IC_W     = clog2(IDLE_MAX + 1);

  logic                 tick;
  logic [1:0]           sync_q;
  logic [2:0]           maj_q;
  logic                 rxs;
  rx_state_e            state_q;
  logic [SC_W-1:0]      sc_q;
  logic [BC_W-1:0]      bc_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_bit_q, perr_q, ferr_q, brk_q, stop2_q, brk_wait_q;
  logic [IC_W-1:0]      idle_cnt_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, perr_out_q, ferr_out_q, brk_out_q, ovr_q;
  logic                 last_d, hs_d, par_req_d;

  uart_os_tick #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(OVS)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Synchroniser runs every clock; the majority filter only on ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      maj_q  <= 3'b111;
    end else begin
      sync_q <= {sync_q[0], rxd};
      if (tick) maj_q <= {maj_q[1:0], sync_q[1]};
    end
  end

  assign rxs       = (maj_q[0] & maj_q[1]) | (maj_q[0] & maj_q[2]) | (maj_q[1] & maj_q[2]);
  assign last_d    = (sc_q == SC_W'(OVS - 1));
  assign hs_d      = valid_q && rx_ready;
  assign par_req_d = (^shift_q) ^ (PARITY == PAR_ODD);

  // sc_q is log2(OVS) wide, so it wraps to 0 by itself after the mid-bit sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sc_q       <= '0;
      bc_q       <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      stop2_q    <= 1'b0;
      brk_wait_q <= 1'b0;
      idle_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      brk_out_q  <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      if (hs_d) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
      case (state_q)
        ST_IDLE: if (tick) begin
          if (!rxs && !brk_wait_q) begin
            state_q    <= ST_START;
            sc_q       <= '0;
            idle_cnt_q <= '0;
          end else if (!rxs) begin
            idle_cnt_q <= '0;
          end else begin
            brk_wait_q <= 1'b0;
            if (idle_cnt_q != IC_W'(IDLE_MAX)) idle_cnt_q <= idle_cnt_q + 1'b1;
          end
        end
        ST_START: if (tick) begin
          if (sc_q == SC_W'(OVS / 2 - 1)) begin
            if (rxs) begin
              state_q <= ST_IDLE;
            end else begin
              state_q   <= ST_DATA;
              sc_q      <= '0;
              bc_q      <= '0;
              par_bit_q <= 1'b0;
              perr_q    <= 1'b0;
              ferr_q    <= 1'b0;
              brk_q     <= 1'b0;
              stop2_q   <= 1'b0;
            end
          end else begin
            sc_q <= sc_q + 1'b1;
          end
        end
        ST_DATA: if (tick) begin
          sc_q <= sc_q + 1'b1;
          if (last_d) begin
            shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
            bc_q    <= bc_q + 1'b1;
            if (bc_q == BC_W'(DATA_BITS - 1))
              state_q <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: if (tick) begin
          sc_q <= sc_q + 1'b1;
          if (last_d) begin
            par_bit_q <= rxs;
            perr_q    <= (rxs != par_req_d);
            state_q   <= ST_STOP;
          end
        end
        ST_STOP: if (tick) begin
          sc_q <= sc_q + 1'b1;
          if (last_d) begin
            if (!rxs) ferr_q <= 1'b1;
            if (!stop2_q) brk_q <= !rxs && (shift_q == '0) && !par_bit_q;
            if (STOP_BITS == 2 && !stop2_q) stop2_q <= 1'b1;
            else                            state_q <= ST_DELIVER;
          end
        end
        ST_DELIVER: begin
          if (!valid_q || hs_d) begin
            data_q     <= shift_q;
            perr_out_q <= perr_q;
            ferr_out_q <= ferr_q;
            brk_out_q  <= brk_q;
            valid_q    <= 1'b1;
          end else begin
            ovr_q <= 1'b1;
          end
          // A break keeps the line low; hold off new starts until it is released.
          brk_wait_q <= brk_q;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_out_q;
  assign break_det  = brk_out_q;
  assign overrun    = ovr_q;
  assign rx_idle    = (idle_cnt_q >= IC_W'(IDLE_MAX));

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 receiver and a 7-bit even-parity, two-stop
// receiver, driven with directed and random frames against a frame-level model.
module tb_uart_rx_param;

  localparam int CLK_HZ   = 1600000;
  localparam int BAUD     = 100000;
  localparam int OVS      = 16;
  localparam int BIT_CLKS = CLK_HZ / BAUD;

  typedef struct packed {
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       brk;
  } word_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxdA, readyA, rxdB, readyB;
  logic [7:0] dataA;
  logic [6:0] dataB;
  logic       validA, peA, feA, brkA, ovrA, idleA;
  logic       validB, peB, feB, brkB, ovrB, idleB;
  logic       monEn;
  word_t      capA[$];
  word_t      capB[$];
  int         compared = 0;
  int         mismatched = 0;

  always #5 clk = ~clk;

  uart_rx_param #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(OVS),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .IDLE_BITS(16)
  ) dutA (
    .clk(clk), .rst_n(rst_n), .rxd(rxdA), .rx_data(dataA), .rx_valid(validA),
    .rx_ready(readyA), .parity_err(peA), .frame_err(feA), .break_det(brkA),
    .overrun(ovrA), .rx_idle(idleA)
  );

  uart_rx_param #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(OVS),
    .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .IDLE_BITS(16)
  ) dutB (
    .clk(clk), .rst_n(rst_n), .rxd(rxdB), .rx_data(dataB), .rx_valid(validB),
    .rx_ready(readyB), .parity_err(peB), .frame_err(feB), .break_det(brkB),
    .overrun(ovrB), .rx_idle(idleB)
  );

  // Every accepted word (valid && ready) is captured for later comparison.
  always @(negedge clk) begin
    if (monEn && rst_n && validA && readyA) capA.push_back(word_t'{9'(dataA), peA, feA, brkA});
    if (monEn && rst_n && validB && readyB) capB.push_back(word_t'{9'(dataB), peB, feB, brkB});
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setLine(input int line, input logic v);
    if (line == 0) rxdA = v;
    else           rxdB = v;
  endtask

  // Frame-level reference: what the receiver must report for a given frame.
  function automatic word_t expectWord(input int nBits, input logic [8:0] data, input int parMode,
                                       input logic parBit, input int nStop,
                                       input logic stop1, input logic stop2);
    word_t      w;
    logic [8:0] mask;
    logic [8:0] d;
    logic       req;
    mask  = (9'h1 << nBits) - 9'h1;
    d     = data & mask;
    req   = (^d) ^ (parMode == 2);
    w.data = d;
    w.pe   = (parMode != 0) && (parBit != req);
    w.fe   = !stop1 || (nStop == 2 && !stop2);
    w.brk  = (d == 9'h0) && (parMode == 0 || !parBit) && !stop1;
    return w;
  endfunction

  task automatic applyStimulus(input int line, input int nBits, input logic [8:0] data,
                               input int parMode, input logic parBit, input int nStop,
                               input logic stop1, input logic stop2);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < nBits; i++) bits.push_back(data[i]);
    if (parMode != 0) bits.push_back(parBit);
    bits.push_back(stop1);
    if (nStop == 2) bits.push_back(stop2);
    for (int i = 0; i < bits.size(); i++) begin
      setLine(line, bits[i]);
      repeat (BIT_CLKS) @(negedge clk);
    end
    setLine(line, 1'b1);
    repeat (3 * BIT_CLKS) @(negedge clk);
  endtask

  task automatic checkCapture(input int line, input word_t exp, input string tag);
    word_t got;
    int    n;
    n = (line == 0) ? capA.size() : capB.size();
    checkOutput({tag, " count"}, n, 1);
    if (n > 0) begin
      if (line == 0) got = capA.pop_front();
      else           got = capB.pop_front();
      checkOutput({tag, " data"}, got.data, exp.data);
      checkOutput({tag, " parity_err"}, got.pe, exp.pe);
      checkOutput({tag, " frame_err"}, got.fe, exp.fe);
      checkOutput({tag, " break_det"}, got.brk, exp.brk);
    end
    while (capA.size() > 0 && line == 0) void'(capA.pop_front());
    while (capB.size() > 0 && line == 1) void'(capB.pop_front());
  endtask

  initial begin
    logic [8:0] d;
    logic       p, s1, s2;

    rst_n = 1'b0; rxdA = 1'b1; rxdB = 1'b1; readyA = 1'b1; readyB = 1'b1; monEn = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset rx_valid", validA, 0);
    checkOutput("reset rx_data", dataA, 0);
    checkOutput("reset flags", {peA, feA, brkA, ovrA}, 0);
    checkOutput("reset rx_idle", idleA, 0);
    checkOutput("reset B outputs", {validB, dataB, peB, feB, brkB, ovrB, idleB}, 0);

    rst_n = 1'b1;
    repeat (255) @(negedge clk);
    checkOutput("rx_idle before 256", idleA, 0);
    @(negedge clk);
    checkOutput("rx_idle at 256", idleA, 1);
    checkOutput("rx_idle B at 256", idleB, 1);

    applyStimulus(0, 8, 9'hA5, 0, 1'b0, 1, 1'b1, 1'b1);
    checkCapture(0, expectWord(8, 9'hA5, 0, 1'b0, 1, 1'b1, 1'b1), "8N1 A5");
    checkOutput("rx_idle after frame", idleA, 0);

    for (int k = 0; k < 8; k++) begin
      d  = 9'($urandom_range(0, 255));
      s1 = ($urandom_range(0, 3) != 0);
      applyStimulus(0, 8, d, 0, 1'b0, 1, s1, 1'b1);
      checkCapture(0, expectWord(8, d, 0, 1'b0, 1, s1, 1'b1), "8N1 random");
    end

    setLine(0, 1'b0);
    repeat (40 * BIT_CLKS) @(negedge clk);
    setLine(0, 1'b1);
    repeat (4 * BIT_CLKS) @(negedge clk);
    checkCapture(0, expectWord(8, 9'h0, 0, 1'b0, 1, 1'b0, 1'b0), "break");

    setLine(0, 1'b0);
    repeat (6) @(negedge clk);
    setLine(0, 1'b1);
    repeat (4 * BIT_CLKS) @(negedge clk);
    checkOutput("glitch no word", capA.size(), 0);

    monEn = 1'b0; readyA = 1'b0;
    applyStimulus(0, 8, 9'h11, 0, 1'b0, 1, 1'b1, 1'b1);
    checkOutput("hold valid", validA, 1);
    checkOutput("hold data", dataA, 8'h11);
    checkOutput("hold no overrun", ovrA, 0);
    applyStimulus(0, 8, 9'h22, 0, 1'b0, 1, 1'b1, 1'b1);
    checkOutput("overrun valid", validA, 1);
    checkOutput("overrun data kept", dataA, 8'h11);
    checkOutput("overrun set", ovrA, 1);
    readyA = 1'b1;
    @(negedge clk);
    checkOutput("handshake clears valid", validA, 0);
    checkOutput("handshake clears overrun", ovrA, 0);

    readyA = 1'b0;
    applyStimulus(0, 8, 9'h5A, 0, 1'b0, 1, 1'b1, 1'b1);
    checkOutput("pre-reset valid", validA, 1);
    setLine(0, 1'b0);
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset valid", validA, 0);
    checkOutput("async reset data", dataA, 0);
    checkOutput("async reset flags", {peA, feA, brkA, ovrA, idleA}, 0);
    setLine(0, 1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b1; readyA = 1'b1; monEn = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    applyStimulus(0, 8, 9'h3C, 0, 1'b0, 1, 1'b1, 1'b1);
    checkCapture(0, expectWord(8, 9'h3C, 0, 1'b0, 1, 1'b1, 1'b1), "after reset 3C");

    applyStimulus(1, 7, 9'h41, 1, 1'b0, 2, 1'b1, 1'b1);
    checkCapture(1, expectWord(7, 9'h41, 1, 1'b0, 2, 1'b1, 1'b1), "7E2 41 good parity");
    applyStimulus(1, 7, 9'h41, 1, 1'b1, 2, 1'b1, 1'b1);
    checkCapture(1, expectWord(7, 9'h41, 1, 1'b1, 2, 1'b1, 1'b1), "7E2 41 bad parity");
    applyStimulus(1, 7, 9'h2B, 1, 1'b0, 2, 1'b1, 1'b0);
    checkCapture(1, expectWord(7, 9'h2B, 1, 1'b0, 2, 1'b1, 1'b0), "7E2 second stop low");

    for (int k = 0; k < 6; k++) begin
      d  = 9'($urandom_range(0, 127));
      p  = 1'($urandom_range(0, 1));
      s1 = ($urandom_range(0, 3) != 0);
      s2 = ($urandom_range(0, 2) != 0);
      applyStimulus(1, 7, d, 1, p, 2, s1, s2);
      checkCapture(1, expectWord(7, d, 1, p, 2, s1, s2), "7E2 random");
    end
    checkOutput("no stray words on A", capA.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
